// File: rtl/patch_pkg.sv
// Shared image/patch geometry and FSM state encoding for the patchifier and unpatchifier.
// Constants only: no latency, no flow control.
package patch_pkg;
  localparam int CHANNEL_SIZE      = 8;
  localparam int NUM_CHANNELS      = 3;
  localparam int PIXEL_WIDTH       = CHANNEL_SIZE * NUM_CHANNELS;
  localparam int IMG_WIDTH         = 16;
  localparam int IMG_HEIGHT        = 16;
  localparam int PATCH_SIZE        = 4;
  localparam int PATCH_SIZE_LOG2   = 2;
  localparam int PATCHES_IN_ROW    = IMG_WIDTH / PATCH_SIZE;
  localparam int TOTAL_NUM_PATCHES = (IMG_WIDTH / PATCH_SIZE) * (IMG_HEIGHT / PATCH_SIZE);
  localparam int PATCH_VECTOR_SIZE = PATCH_SIZE * PATCH_SIZE;

  localparam int PATCH_IDX_W = $clog2(TOTAL_NUM_PATCHES);
  localparam int POS_IDX_W   = $clog2(PATCH_VECTOR_SIZE);
  localparam int ROW_W       = $clog2(IMG_HEIGHT);
  localparam int COL_W       = $clog2(IMG_WIDTH);

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t LOAD = 2'd1;
  localparam state_t DONE = 2'd2;
endpackage

// File: rtl/patch_addr_map.sv
// Maps (patch_idx, pos_idx) in patch-major order to image (row, col).
// Purely combinational, zero latency; no flow control.
module patch_addr_map
  import patch_pkg::*;
(
  input  logic [PATCH_IDX_W-1:0] i_patch_idx,
  input  logic [POS_IDX_W-1:0]   i_pos_idx,
  output logic [ROW_W-1:0]       o_row,
  output logic [COL_W-1:0]       o_col
);

  assign o_row = ROW_W'((32'(i_patch_idx) / PATCHES_IN_ROW) * PATCH_SIZE
                        + (32'(i_pos_idx) >> PATCH_SIZE_LOG2));
  assign o_col = COL_W'((32'(i_patch_idx) % PATCHES_IN_ROW) * PATCH_SIZE
                        + (32'(i_pos_idx) & (PATCH_SIZE - 1)));

endmodule

// File: rtl/unpatchifier.sv
// Rebuilds a full image from a patch-major pixel stream; image_valid 1 cycle after last beat.
// in_ready only in LOAD, image held until output_taken; UNPATCHIFIER_LAST_CHECK_EN adds in_last framing check.
module unpatchifier
  import patch_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIXEL_WIDTH-1:0] in_pixel,
  input  logic                   in_last,
  input  logic                   output_taken,
  output logic [1:0]             state,
  output logic                   image_valid,
  output logic [PIXEL_WIDTH-1:0] image [IMG_HEIGHT][IMG_WIDTH],
  output logic                   err
);

  state_t                 r_state;
  logic [PATCH_IDX_W-1:0] r_patch_idx;
  logic [POS_IDX_W-1:0]   r_pos_idx;
  logic [PIXEL_WIDTH-1:0] r_image [IMG_HEIGHT][IMG_WIDTH];

  logic             w_beat;
  logic             w_pos_wrap;
  logic             w_final;
  logic [ROW_W-1:0] w_row;
  logic [COL_W-1:0] w_col;

  assign w_beat     = in_valid && (r_state == LOAD);
  assign w_pos_wrap = (r_pos_idx == POS_IDX_W'(PATCH_VECTOR_SIZE - 1));
  assign w_final    = w_pos_wrap && (r_patch_idx == PATCH_IDX_W'(TOTAL_NUM_PATCHES - 1));

  patch_addr_map u_addr_map (
    .i_patch_idx (r_patch_idx),
    .i_pos_idx   (r_pos_idx),
    .o_row       (w_row),
    .o_col       (w_col)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_patch_idx <= '0;
      r_pos_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (en) begin
            r_state     <= LOAD;
            r_patch_idx <= '0;
            r_pos_idx   <= '0;
          end
        end
        LOAD: begin
          if (w_beat) begin
            if (w_final) begin
              r_state     <= DONE;
              r_patch_idx <= '0;
              r_pos_idx   <= '0;
            end else if (w_pos_wrap) begin
              r_pos_idx   <= '0;
              r_patch_idx <= r_patch_idx + 1'b1;
            end else begin
              r_pos_idx   <= r_pos_idx + 1'b1;
            end
          end
        end
        // en is deliberately ignored here: a new load needs a fresh en in IDLE.
        DONE: begin
          if (output_taken) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < IMG_HEIGHT; r++) begin
        for (int c = 0; c < IMG_WIDTH; c++) begin
          r_image[r][c] <= '0;
        end
      end
    end else if (w_beat) begin
      r_image[w_row][w_col] <= in_pixel;
    end
  end

  assign in_ready    = (r_state == LOAD);
  assign image_valid = (r_state == DONE);
  assign state       = r_state;
  assign image       = r_image;

`ifdef UNPATCHIFIER_LAST_CHECK_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if ((r_state == IDLE) && en) begin
      r_err <= 1'b0;
    end else if (w_beat && (in_last != w_final)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused_last;
  assign w_unused_last = in_last;
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_unpatchifier.sv
// Directed bench for unpatchifier: full loads, stalls, partial overwrite, DONE handshake,
// mid-load reset and (when UNPATCHIFIER_LAST_CHECK_EN is defined) the in_last framing check.
module tb_unpatchifier;
  import patch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_pixel;
  logic        in_last;
  logic        output_taken;
  logic [1:0]  state;
  logic        image_valid;
  logic [23:0] image [16][16];
  logic        err;

  int total = 0;
  int bad   = 0;

  unpatchifier dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pixel     (in_pixel),
    .in_last      (in_last),
    .output_taken (output_taken),
    .state        (state),
    .image_valid  (image_valid),
    .image        (image),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Pixel tag: {salt, patch, pos}.
  function automatic logic [23:0] tag(input int p, input int q, input logic [7:0] s);
    logic [7:0] pp;
    logic [7:0] qq;
    pp = p[7:0];
    qq = q[7:0];
    return {s, pp, qq};
  endfunction

  // Expected tag at image[r][c] for a tagged stream (4x4 patches, 4 patches per row).
  function automatic logic [23:0] exp_at(input int r, input int c, input logic [7:0] s);
    return tag((r / 4) * 4 + (c / 4), (r % 4) * 4 + (c % 4), s);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    en = 1'b1;
    step();
    en = 1'b0;
  endtask

  task automatic take();
    output_taken = 1'b1;
    step();
    output_taken = 1'b0;
  endtask

  task automatic send_beats(input int first, input int n, input logic [7:0] s, input int last_at);
    for (int b = first; b < first + n; b++) begin
      in_valid = 1'b1;
      in_pixel = tag(b / 16, b % 16, s);
      in_last  = (b == last_at);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    int nz;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if (image_valid !== 1'b0) begin bad++; $display("FAIL reset_image_valid got=%b want=0", image_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    nz = 0;
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) if (image[r][c] !== 24'h0) nz++;
    total++; if (nz != 0) begin bad++; $display("FAIL reset_image nonzero_pixels=%0d want=0", nz); end
  endtask

  task automatic test_full_stream();
    int wrong;
    start_load();
    total++; if (state !== 2'd1) begin bad++; $display("FAIL full_load_state got=%0d want=1", state); end
    send_beats(0, 255, 8'h00, 255);
    total++; if (image_valid !== 1'b0) begin bad++; $display("FAIL full_valid_early got=%b want=0", image_valid); end
    send_beats(255, 1, 8'h00, 255);
    total++; if (image_valid !== 1'b1) begin bad++; $display("FAIL full_valid_at_257 got=%b want=1", image_valid); end
    total++; if (state !== 2'd2) begin bad++; $display("FAIL full_done_state got=%0d want=2", state); end
    total++; if (image[5][6] !== 24'h000506) begin bad++; $display("FAIL full_px_5_6 got=%h want=000506", image[5][6]); end
    total++; if (image[3][4] !== 24'h00010C) begin bad++; $display("FAIL full_px_3_4 got=%h want=00010c", image[3][4]); end
    total++; if (image[15][15] !== 24'h000F0F) begin bad++; $display("FAIL full_px_15_15 got=%h want=000f0f", image[15][15]); end
    wrong = 0;
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) if (image[r][c] !== exp_at(r, c, 8'h00)) wrong++;
    total++; if (wrong != 0) begin bad++; $display("FAIL full_image wrong_pixels=%0d want=0", wrong); end
  endtask

  task automatic test_done_handshake();
    in_valid = 1'b1;
    in_pixel = 24'hDEAD00;
    step();
    step();
    total++; if (state !== 2'd2) begin bad++; $display("FAIL done_hold_state got=%0d want=2", state); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL done_in_ready got=%b want=0", in_ready); end
    total++; if (image[0][0] !== 24'h000000) begin bad++; $display("FAIL done_px_0_0 got=%h want=000000", image[0][0]); end
    en           = 1'b1;
    output_taken = 1'b1;
    step();
    en           = 1'b0;
    output_taken = 1'b0;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL done_en_take_state got=%0d want=0", state); end
    step();
    total++; if (state !== 2'd0) begin bad++; $display("FAIL idle_no_en_state got=%0d want=0", state); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL idle_in_ready got=%b want=0", in_ready); end
    total++; if (image[1][1] !== 24'h000005) begin bad++; $display("FAIL idle_px_1_1 got=%h want=000005", image[1][1]); end
    in_valid = 1'b0;
  endtask

  task automatic test_gaps();
    int beats;
    int cyc;
    int rdy_bad;
    int early;
    int wrong;
    start_load();
    beats = 0; cyc = 0; rdy_bad = 0; early = 0;
    while (beats < 256 && cyc < 3000) begin
      in_valid = 1'($urandom_range(0, 1));
      in_pixel = in_valid ? tag(beats / 16, beats % 16, 8'h33) : 24'hFFFFFF;
      if (in_ready !== 1'b1) rdy_bad++;
      if (image_valid !== 1'b0) early++;
      step();
      if (in_valid) beats++;
      cyc++;
    end
    in_valid = 1'b0;
    total++; if (beats != 256) begin bad++; $display("FAIL gaps_timeout beats=%0d want=256", beats); end
    total++; if (rdy_bad != 0) begin bad++; $display("FAIL gaps_in_ready low_cycles=%0d want=0", rdy_bad); end
    total++; if (early != 0) begin bad++; $display("FAIL gaps_early_valid cycles=%0d want=0", early); end
    total++; if (image_valid !== 1'b1) begin bad++; $display("FAIL gaps_valid got=%b want=1", image_valid); end
    wrong = 0;
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) if (image[r][c] !== exp_at(r, c, 8'h33)) wrong++;
    total++; if (wrong != 0) begin bad++; $display("FAIL gaps_image wrong_pixels=%0d want=0", wrong); end
    take();
  endtask

  task automatic test_partial_overwrite();
    int wrong;
    start_load();
    send_beats(0, 10, 8'h44, 255);
    step();
    step();
    step();
    total++; if (image[2][1] !== 24'h440009) begin bad++; $display("FAIL partial_new_px got=%h want=440009", image[2][1]); end
    total++; if (image[2][2] !== 24'h33000A) begin bad++; $display("FAIL partial_old_px got=%h want=33000a", image[2][2]); end
    total++; if (image[15][15] !== 24'h330F0F) begin bad++; $display("FAIL partial_old_last got=%h want=330f0f", image[15][15]); end
    send_beats(10, 246, 8'h44, 255);
    total++; if (image_valid !== 1'b1) begin bad++; $display("FAIL partial_valid got=%b want=1", image_valid); end
    wrong = 0;
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) if (image[r][c] !== exp_at(r, c, 8'h44)) wrong++;
    total++; if (wrong != 0) begin bad++; $display("FAIL partial_image wrong_pixels=%0d want=0", wrong); end
    take();
  endtask

  task automatic test_round_trip();
    logic [23:0] src [16][16];
    int wrong;
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) src[r][c] = 24'($urandom);
    start_load();
    for (int pr = 0; pr < 4; pr++)
      for (int pc = 0; pc < 4; pc++)
        for (int y = 0; y < 4; y++)
          for (int x = 0; x < 4; x++) begin
            in_valid = 1'b1;
            in_pixel = src[pr * 4 + y][pc * 4 + x];
            in_last  = (pr == 3 && pc == 3 && y == 3 && x == 3);
            step();
          end
    in_valid = 1'b0;
    in_last  = 1'b0;
    total++; if (image_valid !== 1'b1) begin bad++; $display("FAIL rt_valid got=%b want=1", image_valid); end
    wrong = 0;
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) if (image[r][c] !== src[r][c]) wrong++;
    total++; if (wrong != 0) begin bad++; $display("FAIL rt_image wrong_pixels=%0d want=0", wrong); end
    take();
  endtask

  task automatic test_reset_midload();
    int nz;
    int wrong;
    start_load();
    send_beats(0, 100, 8'h55, 255);
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL midrst_state got=%0d want=0", state); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready got=%b want=0", in_ready); end
    nz = 0;
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) if (image[r][c] !== 24'h0) nz++;
    total++; if (nz != 0) begin bad++; $display("FAIL midrst_image nonzero_pixels=%0d want=0", nz); end
    start_load();
    send_beats(0, 255, 8'h66, 255);
    total++; if (image_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid_early got=%b want=0", image_valid); end
    send_beats(255, 1, 8'h66, 255);
    total++; if (image_valid !== 1'b1) begin bad++; $display("FAIL midrst_valid got=%b want=1", image_valid); end
    wrong = 0;
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) if (image[r][c] !== exp_at(r, c, 8'h66)) wrong++;
    total++; if (wrong != 0) begin bad++; $display("FAIL midrst_image wrong_pixels=%0d want=0", wrong); end
    take();
  endtask

  task automatic test_last_check();
`ifdef UNPATCHIFIER_LAST_CHECK_EN
    start_load();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL last_err_start got=%b want=0", err); end
    send_beats(0, 200, 8'h77, 199);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL last_err_set got=%b want=1", err); end
    send_beats(200, 56, 8'h77, 199);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL last_err_sticky got=%b want=1", err); end
    total++; if (image_valid !== 1'b1) begin bad++; $display("FAIL last_valid got=%b want=1", image_valid); end
    take();
    start_load();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL last_err_clear got=%b want=0", err); end
    send_beats(0, 256, 8'h78, 255);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL last_err_clean got=%b want=0", err); end
    total++; if (image_valid !== 1'b1) begin bad++; $display("FAIL last_clean_valid got=%b want=1", image_valid); end
    take();
`else
    start_load();
    send_beats(0, 256, 8'h77, 199);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL last_err_tied got=%b want=0", err); end
    total++; if (image_valid !== 1'b1) begin bad++; $display("FAIL last_valid got=%b want=1", image_valid); end
    take();
`endif
  endtask

  initial begin
    reset        = 1'b1;
    en           = 1'b0;
    in_valid     = 1'b0;
    in_pixel     = 24'h0;
    in_last      = 1'b0;
    output_taken = 1'b0;
    test_reset();
    test_full_stream();
    test_done_handshake();
    test_gaps();
    test_partial_overwrite();
    test_round_trip();
    test_reset_midload();
    test_last_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unpatchifier.md
Name: unpatchifier

Overview:
- Inverse of the patchifier: rebuilds a full image from a stream of patch pixels.
- Input order is patch-major: patch 0..TOTAL_NUM_PATCHES-1, then position 0..PATCH_VECTOR_SIZE-1 within each patch. This matches the all_patches layout.
- Sits after transformer output projection and before image-space post-processing and debug dump.
- The full image is held in a register array until the consumer takes it.

Parameters:
- CHANNEL_SIZE, 8, bits per colour channel
- NUM_CHANNELS, 3, channels per pixel
- PIXEL_WIDTH, CHANNEL_SIZE*NUM_CHANNELS, pixel word width
- IMG_WIDTH, 16, image columns
- IMG_HEIGHT, 16, image rows
- PATCH_SIZE, 4, patch edge in pixels; must be a power of 2
- PATCH_SIZE_LOG2, 2, log2(PATCH_SIZE)
- PATCHES_IN_ROW, IMG_WIDTH/PATCH_SIZE, patches per patch-row
- TOTAL_NUM_PATCHES, (IMG_WIDTH/PATCH_SIZE)*(IMG_HEIGHT/PATCH_SIZE), patch count
- PATCH_VECTOR_SIZE, PATCH_SIZE*PATCH_SIZE, pixels per patch

Ports:
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high reset
- en  in  1  start a new image load (sampled in IDLE)
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept a pixel
- in_pixel  in  PIXEL_WIDTH  pixel data
- in_last  in  1  marks final pixel of final patch (used only with the optional feature)
- output_taken  in  1  consumer has taken the image
- state  out  2  current FSM state
- image_valid  out  1  image array is complete and stable
- image  out  PIXEL_WIDTH x [IMG_HEIGHT][IMG_WIDTH]  reassembled image; first index is row
- err  out  1  sticky framing error (optional feature only; tied 0 otherwise)

Behaviour:
- FSM encoding: IDLE=2'd0, LOAD=2'd1, DONE=2'd2.
  - IDLE -> LOAD when en=1; patch_idx and pos_idx clear to 0.
  - LOAD -> DONE on the handshake where patch_idx=TOTAL_NUM_PATCHES-1 and pos_idx=PATCH_VECTOR_SIZE-1.
  - DONE -> IDLE when output_taken=1.
  - en outside IDLE is ignored. en together with output_taken in DONE: go to IDLE only; en must be re-asserted.
- Handshake: in_ready = (state==LOAD). A beat transfers when in_valid && in_ready. No combinational path from in_valid to in_ready.
- Write on each beat: image[row][col] <= in_pixel, where
  - row = (patch_idx>>PATCH_SIZE_LOG2... precisely: (patch_idx / PATCHES_IN_ROW)*PATCH_SIZE + (pos_idx>>PATCH_SIZE_LOG2)
  - col = (patch_idx % PATCHES_IN_ROW)*PATCH_SIZE + (pos_idx & (PATCH_SIZE-1))
  - Registered write, one pixel per cycle.
- Counter advance per beat:
  - pos_idx increments.
  - At PATCH_VECTOR_SIZE-1, pos_idx wraps to 0 and patch_idx increments.
  - At the final beat both counters wrap to 0.
- Stalls: in_valid=0 in LOAD holds the counters and the image.
- image_valid = (state==DONE). It rises the cycle after the final beat, so latency is 1 cycle from last handshake. Minimum load time is TOTAL_NUM_PATCHES*PATCH_VECTOR_SIZE cycles (256 at defaults).
- image is held unchanged in DONE and IDLE. Pixels not yet written in a new load keep their previous values.
- Reset (including mid-LOAD): state=IDLE, counters=0, image all zero, image_valid=0, in_ready=0, err=0.
- Beats offered in IDLE or DONE are not accepted (in_ready=0).

Optional Feature:
- Macro: UNPATCHIFIER_LAST_CHECK_EN.
- Defined:
  - An accepted beat whose in_last differs from (final-beat condition) sets err.
  - err is sticky until reset or the next IDLE->LOAD transition.
  - The FSM still sequences by count alone.
- Undefined: in_last is ignored and err is tied 0.

Decomposition:
- patch_pkg holds:
  - all geometry constants: PIXEL_WIDTH, PATCHES_IN_ROW, TOTAL_NUM_PATCHES, PATCH_VECTOR_SIZE
  - the state typedef (IDLE/LOAD/DONE), shared with the patchifier
- Sub-module patch_addr_map: purely combinational (patch_idx, pos_idx) -> (row, col). It is reusable by the patchifier for its forward mapping.

Test Plan:
- Full stream of 256 beats, in_pixel = {patch,pos} tag, in_valid=1 throughout -> image[5][6] = tag{patch 5, pos 6}; image_valid high at cycle 257 after en; state=2.
- Round-trip: drive patchifier output for a random image into the unpatchifier -> image bit-identical to the source.
- Random in_valid gaps (50% duty) -> same final image; counters hold during gaps; in_ready=1 for all of LOAD.
- Reset asserted after 100 beats, then en and a full stream -> clean load; image_valid only after a full 256 beats post-reset.
- In DONE, en=1 and output_taken=1 in the same cycle -> state=IDLE next cycle, not LOAD; in_ready=0 in IDLE and DONE.
- With UNPATCHIFIER_LAST_CHECK_EN: in_last on beat 200 -> err=1 and sticky, image still completes at beat 256; next en clears err.
